// File: rtl/uart_drain_pkg.sv
// Shared types and constants for the UART FIFO read-side drain sequencer.
package uart_drain_pkg;

    localparam int RD_LAT_DEF = 2;
    localparam int FIFO_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/uart_fifo_drain_ctrl.sv
// Pops the UART FIFO one byte at a time, absorbs its read latency and hands bytes to TX.
// Optional drain-complete interrupt is built when UART_DRAIN_IRQ_EN is defined.
module uart_fifo_drain_ctrl
    import uart_drain_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [FIFO_W-1:0] fifo_do,
    output logic              fifo_rd_n,
    output logic [FIFO_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_count
`ifdef UART_DRAIN_IRQ_EN
    ,
    input  logic              irq_clr,
    output logic              drain_irq
`endif
);

    state_t            state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic              flush_seen_q, flush_seen_d;
    logic [FIFO_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    // Flush beats tx_ready in the same HOLD cycle.
    assign accept = (state_q == HOLD) && tx_ready && !flush;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        flush_seen_d = flush_seen_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                flush_seen_d = 1'b0;
                if ((enable || flush) && !fifo_empty) state_d = POP;
            end
            POP: begin
                lat_d        = 3'(RD_LAT - 1);
                flush_seen_d = flush;
                state_d      = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (flush) flush_seen_d = 1'b1;
                if (lat_q == 3'd0) begin
                    data_d  = fifo_do;
                    state_d = (flush_seen_q || flush) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (accept) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            flush_seen_q <= 1'b0;
            data_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            flush_seen_q <= flush_seen_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
        end
    end

    assign fifo_rd_n = (state_q != POP);
    assign tx_valid  = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign tx_data   = data_q;
    assign tx_count  = cnt_q;

`ifdef UART_DRAIN_IRQ_EN
    logic sent_q, irq_q, irq_set;

    // Fires only on the transition back to IDLE, so a clear while parked in IDLE sticks.
    assign irq_set = (state_q != IDLE) && (state_d == IDLE) && fifo_empty && (sent_q || accept);

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            sent_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            sent_q <= irq_clr ? 1'b0 : (sent_q || accept);
            irq_q  <= irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
        end
    end

    assign drain_irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_fifo_drain_ctrl.sv
// Randomized bench for uart_fifo_drain_ctrl against a queue-based FIFO and transfer model.
module tb_uart_fifo_drain_ctrl;
    import uart_drain_pkg::*;

    localparam int RD_LAT = RD_LAT_DEF;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              aresetn = 1'b0;
    logic              enable = 1'b0, flush = 1'b0, fifo_empty = 1'b1, tx_ready = 1'b0;
    logic [FIFO_W-1:0] fifo_do = '0;
    logic              fifo_rd_n, tx_valid, busy;
    logic [FIFO_W-1:0] tx_data;
    logic [CNT_W-1:0]  tx_count;
`ifdef UART_DRAIN_IRQ_EN
    logic              irq_clr = 1'b0;
    logic              drain_irq;
`endif

    uart_fifo_drain_ctrl #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clock(clock), .aresetn(aresetn), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_do(fifo_do), .fifo_rd_n(fifo_rd_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .tx_count(tx_count)
`ifdef UART_DRAIN_IRQ_EN
        , .irq_clr(irq_clr), .drain_irq(drain_irq)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO contents plus the life of the single in-flight byte.
    logic [FIFO_W-1:0] fifo_q[$];
    int                cyc = 0, pop_cyc = 0, n_acc = 0;
    bit                mon_en = 0, inflight = 0, dropped = 0, hold_exp = 0, cond_prev = 0;
    logic [FIFO_W-1:0] inflight_val = '0;
    logic [CNT_W-1:0]  cnt_exp = '0;

    always @(negedge clock) begin
        bit popped, idle_now;
        cyc++;
        if (mon_en) begin
            popped   = (fifo_rd_n == 1'b0);
            idle_now = !inflight && !popped;
            chk("pop_strobe", popped, cond_prev);
            if (popped) begin
                chk("one_in_flight", inflight, 0);
                chk("pop_nonempty", fifo_q.size() != 0, 1);
                inflight     = 1;
                dropped      = 0;
                pop_cyc      = cyc;
                inflight_val = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
                fifo_empty   = (fifo_q.size() == 0);
            end
            fifo_do = (inflight && cyc == pop_cyc + RD_LAT) ? inflight_val : FIFO_W'($urandom);
            if (inflight && !dropped && cyc == pop_cyc + RD_LAT + 1) hold_exp = 1;
            chk("busy", busy, inflight);
            chk("tx_valid", tx_valid, hold_exp);
            if (hold_exp) chk("tx_data", tx_data, inflight_val);
            chk("tx_count", tx_count, cnt_exp);
            if (hold_exp) begin
                if (flush) begin
                    hold_exp = 0; inflight = 0;
                end else if (tx_ready) begin
                    hold_exp = 0; inflight = 0; cnt_exp++; n_acc++;
                end
            end else if (inflight) begin
                if (flush) dropped = 1;
                if (cyc == pop_cyc + RD_LAT && dropped) inflight = 0;
            end
            cond_prev = idle_now && (enable || flush) && !fifo_empty;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [FIFO_W-1:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_drained(input string tag);
        int i = 0;
        while ((fifo_q.size() != 0 || inflight) && i < 400) begin
            tick(1);
            i++;
        end
        chk(tag, i < 400, 1);
        tick(2);
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!tx_valid && i < 50) begin
            tick(1);
            i++;
        end
        chk(tag, tx_valid, 1);
    endtask

    task automatic wait_pop(input string tag);
        int i = 0;
        while (fifo_rd_n && i < 50) begin
            tick(1);
            i++;
        end
        chk(tag, fifo_rd_n, 0);
    endtask

    initial begin
        tick(2);
        chk("rst_rd_n", fifo_rd_n, 1);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", tx_count, 0);
        aresetn = 1'b1;
        mon_en  = 1;
        tick(2);

        // single byte, full latency path
        push(8'h41); enable = 1'b1; tx_ready = 1'b1;
        wait_drained("t1_drain");
        chk("t1_count", tx_count, 1);

        // backpressure holds the first byte stable, then all four in order
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(FIFO_W'(8'h10 + i));
        wait_valid("t2_valid");
        tick(5);
        chk("t2_hold_valid", tx_valid, 1);
        chk("t2_hold_data", tx_data, 8'h10);
        tx_ready = 1'b1;
        wait_drained("t2_drain");
        chk("t2_count", tx_count, 5);

        // flush in HOLD with tx_ready beats the accept, then empties the FIFO
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(FIFO_W'(8'hA0 + i));
        wait_valid("t3_valid");
        enable = 1'b0; flush = 1'b1; tx_ready = 1'b1;
        wait_drained("t3_drain");
        flush = 1'b0;
        tick(2);
        chk("t3_count", tx_count, 5);
        chk("t3_busy", busy, 0);
        chk("t3_empty", fifo_empty, 1);

        // enable drops while waiting on the FIFO: that byte still completes
        push(8'hB0); push(8'hB1); enable = 1'b1;
        wait_pop("t4_pop");
        tick(1);
        enable = 1'b0;
        tick(20);
        chk("t4_left", fifo_q.size(), 1);
        chk("t4_count", tx_count, 6);
        enable = 1'b1;
        wait_drained("t4_drain");
        chk("t4_count2", tx_count, 7);

        // 16 more transfers wrap the counter back to the same value
        for (int i = 0; i < 16; i++) push(FIFO_W'($urandom));
        wait_drained("t5_drain");
        chk("t5_wrap", tx_count, 7);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            enable   = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            tx_ready = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) push(FIFO_W'($urandom));
            tick(1);
        end
        enable = 1'b1; flush = 1'b0; tx_ready = 1'b1;
        wait_drained("rnd_drain");
        chk("rnd_count", tx_count, n_acc % (1 << CNT_W));

`ifdef UART_DRAIN_IRQ_EN
        irq_clr = 1'b1; tick(1); irq_clr = 1'b0; tick(1);
        chk("irq_clr0", drain_irq, 0);
        push(8'h55); push(8'h66);
        wait_drained("irq_drain");
        tick(2);
        chk("irq_set", drain_irq, 1);
        irq_clr = 1'b1; tick(1); irq_clr = 1'b0; tick(1);
        chk("irq_clr1", drain_irq, 0);
        tick(10);
        chk("irq_quiet", drain_irq, 0);
`endif

        // asynchronous reset while a pop is outstanding; that byte is lost
        push(8'hC0);
        wait_pop("rst_pop");
        tick(1);
        aresetn = 1'b0; mon_en = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", tx_valid, 0);
        chk("arst_rd_n", fifo_rd_n, 1);
        chk("arst_count", tx_count, 0);
        inflight = 0; hold_exp = 0; dropped = 0; cond_prev = 0; cnt_exp = '0;
        tick(2);
        aresetn = 1'b1; mon_en = 1;
        tick(10);
        chk("arst_after", tx_count, 0);
        chk("arst_fifo", fifo_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
